// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// Free-running VGA raster timing generator. Two registered counters (h_cnt
// over clocks in a line, v_cnt over lines in a frame) are decoded
// combinationally into sync pulses, the active-pixel flag, and a pixel request
// (pix_x/pix_y) to an external data stage. The request leads the active window
// by one clock so that the data stage's registered pix_data lands exactly
// when rgb_valid is high.
//
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_cnt) that increments each time the raster wraps to (0,0).
//
// Ports:
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   pix_data   in   [15:0] RGB565 from the data stage (one clock after request)
//   pix_x      out  [9:0]  requested column, 10'h3ff when no request
//   pix_y      out  [9:0]  requested row, 10'h3ff when no request
//   hsync      out  horizontal sync, high during the pulse
//   vsync      out  vertical sync, high during the pulse
//   rgb        out  [15:0] RGB565 to the pins, zero outside the active area
//   rgb_valid  out  high while rgb carries an active pixel
//   frame_cnt  out  [15:0] completed frames (VGA_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // Window boundaries sized to the 10-bit counters.
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_VALID);
  // Request window: active horizontal window pulled one clock earlier.
  localparam logic [9:0] H_REQ_START = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       line_end;
  logic       frame_end;
  logic       h_act;
  logic       v_act;
  logic       h_req;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is in the sensitivity list, so it acts
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + 10'd1;
      if (line_end) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // Counters at zero (including during reset) decode to hsync=vsync=1 and
  // no request / no active pixel, which is the required reset output state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    hsync     = 1'b0;
    vsync     = 1'b0;
    h_act     = 1'b0;
    v_act     = 1'b0;
    h_req     = 1'b0;
    rgb_valid = 1'b0;
    rgb       = '0;
    pix_x     = 10'h3ff;
    pix_y     = 10'h3ff;

    hsync = (h_cnt < H_SYNC_END);
    vsync = (v_cnt < V_SYNC_END);
    h_act = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    v_act = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    h_req = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);

    rgb_valid = h_act && v_act;
    if (rgb_valid) begin
      rgb = pix_data;
    end

    if (h_req && v_act) begin
      pix_x = h_cnt - H_REQ_START;
      pix_y = v_cnt - V_ACT_START;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts raster wraps; rolls over from 16'hffff to 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  // frame_end only feeds the optional frame counter.
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//
// Directed bench for vga_timing_ctrl. One instance uses the default 640x480
// timing for line-level checks; a second, miniature instance (20 clocks x 12
// lines) exercises whole-frame behaviour in a few hundred clocks. Each DUT has
// a registered data stage that returns 16'hF800 for every valid request.
// Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_s_n;

  // Default-timing DUT signals
  logic [15:0] pix_data_d = '0;
  logic [9:0]  pix_x_d, pix_y_d;
  logic        hsync_d, vsync_d, rgb_valid_d;
  logic [15:0] rgb_d;

  // Miniature-timing DUT signals
  logic [15:0] pix_data_s = '0;
  logic [9:0]  pix_x_s, pix_y_s;
  logic        hsync_s, vsync_s, rgb_valid_s;
  logic [15:0] rgb_s;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_d, frame_cnt_s;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int kd = 0;  // posedges since default DUT left reset
  int ks = 0;  // posedges since mini DUT left reset

  always #5 clk = ~clk;

  vga_timing_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_data  (pix_data_d),
    .pix_x     (pix_x_d),
    .pix_y     (pix_y_d),
    .hsync     (hsync_d),
    .vsync     (vsync_d),
    .rgb       (rgb_d),
    .rgb_valid (rgb_valid_d)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_d)
`endif
  );

  vga_timing_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_TOTAL(20),
    .V_SYNC(2), .V_BACK(2), .V_VALID(5), .V_TOTAL(12)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_s_n),
    .pix_data  (pix_data_s),
    .pix_x     (pix_x_s),
    .pix_y     (pix_y_s),
    .hsync     (hsync_s),
    .vsync     (vsync_s),
    .rgb       (rgb_s),
    .rgb_valid (rgb_valid_s)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_s)
`endif
  );

  // Data stages: one-clock registered response to a pixel request.
  always @(posedge clk) begin
    pix_data_d <= (pix_x_d != 10'h3ff && pix_y_d != 10'h3ff) ? 16'hF800 : 16'h0000;
    pix_data_s <= (pix_x_s != 10'h3ff && pix_y_s != 10'h3ff) ? 16'hF800 : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic goto_d(input int target);
    while (kd < target) begin
      @(negedge clk);
      kd++;
    end
  endtask

  task automatic goto_s(input int target);
    while (ks < target) begin
      @(negedge clk);
      ks++;
    end
  endtask

  task automatic check_reset_d(input string tag);
    check({tag, " hsync"},     hsync_d,     1'b1);
    check({tag, " vsync"},     vsync_d,     1'b1);
    check({tag, " rgb_valid"}, rgb_valid_d, 1'b0);
    check({tag, " rgb"},       rgb_d,       16'h0000);
    check({tag, " pix_x"},     pix_x_d,     10'h3ff);
    check({tag, " pix_y"},     pix_y_d,     10'h3ff);
  endtask

  task automatic check_reset_s(input string tag);
    check({tag, " hsync"},     hsync_s,     1'b1);
    check({tag, " vsync"},     vsync_s,     1'b1);
    check({tag, " rgb_valid"}, rgb_valid_s, 1'b0);
    check({tag, " rgb"},       rgb_s,       16'h0000);
    check({tag, " pix_x"},     pix_x_s,     10'h3ff);
    check({tag, " pix_y"},     pix_y_s,     10'h3ff);
  endtask

  initial begin
    int n_valid, n_red, n_leak, n_vs, n_hs;
    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_d("rst_d");
    check_reset_s("rst_s");

    // ---------------- miniature DUT: frame-level behaviour ----------------
    rst_s_n = 1'b1;  // released on a falling edge; ks counts following posedges
    ks = 0;
    check("s k0 hsync", hsync_s, 1'b1);
    check("s k0 vsync", vsync_s, 1'b1);
    goto_s(3);   check("s k3 hsync", hsync_s, 1'b1);
    goto_s(4);   check("s k4 hsync", hsync_s, 1'b0);
    goto_s(20);  check("s k20 hsync", hsync_s, 1'b1);
    goto_s(39);  check("s k39 vsync", vsync_s, 1'b1);
    goto_s(40);  check("s k40 vsync", vsync_s, 1'b0);
    // Row 4 (first active row): request at h=6..13, active at h=7..14.
    goto_s(85);  check("s r4h5 pix_x", pix_x_s, 10'h3ff);
    goto_s(86);
    check("s r4h6 pix_x", pix_x_s, 10'd0);
    check("s r4h6 pix_y", pix_y_s, 10'd0);
    check("s r4h6 valid", rgb_valid_s, 1'b0);
    goto_s(87);
    check("s r4h7 valid", rgb_valid_s, 1'b1);
    check("s r4h7 rgb", rgb_s, 16'hF800);
    check("s r4h7 pix_x", pix_x_s, 10'd1);
    goto_s(93);  check("s r4h13 pix_x", pix_x_s, 10'd7);
    goto_s(94);
    check("s r4h14 pix_x", pix_x_s, 10'h3ff);
    check("s r4h14 valid", rgb_valid_s, 1'b1);
    check("s r4h14 rgb", rgb_s, 16'hF800);
    goto_s(95);
    check("s r4h15 valid", rgb_valid_s, 1'b0);
    check("s r4h15 rgb", rgb_s, 16'h0000);
    goto_s(166);
    check("s r8h6 pix_y", pix_y_s, 10'd4);
    check("s r8h6 pix_x", pix_x_s, 10'd0);
    goto_s(186); check("s r9h6 pix_y", pix_y_s, 10'h3ff);
    goto_s(187); check("s r9h7 valid", rgb_valid_s, 1'b0);
    goto_s(239);
    check("s last vsync", vsync_s, 1'b0);
    check("s last hsync", hsync_s, 1'b0);
    // Second frame: tally a whole frame, then check the wrap.
    goto_s(240);
    n_valid = 0; n_red = 0; n_leak = 0; n_vs = 0; n_hs = 0;
    for (int i = 0; i < 240; i++) begin
      if (rgb_valid_s) n_valid++;
      if (rgb_s == 16'hF800) n_red++;
      if (!rgb_valid_s && rgb_s != 16'h0000) n_leak++;
      if (vsync_s) n_vs++;
      if (hsync_s) n_hs++;
      goto_s(ks + 1);
    end
    check("s frame valid count", n_valid, 40);
    check("s frame F800 count", n_red, 40);
    check("s frame rgb leak", n_leak, 0);
    check("s frame vsync count", n_vs, 40);
    check("s frame hsync count", n_hs, 48);
    check("s wrap hsync", hsync_s, 1'b1);
    check("s wrap vsync", vsync_s, 1'b1);
`ifdef VGA_FRAME_CNT_EN
    goto_s(719); check("s frame_cnt 2", frame_cnt_s, 16'd2);
    goto_s(720); check("s frame_cnt 3", frame_cnt_s, 16'd3);
`endif
    // Mid-frame reset at row 5, h=10 (inside the active area).
    goto_s(830);
    check("s pre-rst valid", rgb_valid_s, 1'b1);
    #1 rst_s_n = 1'b0;
    #1 check_reset_s("s midrst");
`ifdef VGA_FRAME_CNT_EN
    check("s midrst frame_cnt", frame_cnt_s, 16'd0);
`endif
    repeat (2) @(negedge clk);
    check_reset_s("s held");
    rst_s_n = 1'b1;
    ks = 0;
    check("s rel k0 hsync", hsync_s, 1'b1);
    goto_s(3);  check("s rel k3 hsync", hsync_s, 1'b1);
    goto_s(4);  check("s rel k4 hsync", hsync_s, 1'b0);

    // ---------------- default DUT: 640x480 line timing ----------------
    check_reset_d("rst_d late");
    rst_n = 1'b1;
    kd = 0;
    check("d k0 hsync", hsync_d, 1'b1);
    check("d k0 vsync", vsync_d, 1'b1);
    goto_d(95);   check("d k95 hsync", hsync_d, 1'b1);
    goto_d(96);   check("d k96 hsync", hsync_d, 1'b0);
    goto_d(799);  check("d k799 hsync", hsync_d, 1'b0);
    goto_d(800);  check("d k800 hsync", hsync_d, 1'b1);
    goto_d(1599); check("d k1599 vsync", vsync_d, 1'b1);
    goto_d(1600); check("d k1600 vsync", vsync_d, 1'b0);
    goto_d(34 * 800 + 400);
    check("d v34 pix_y", pix_y_d, 10'h3ff);
    check("d v34 valid", rgb_valid_d, 1'b0);
    // Line 35: first active line.
    goto_d(35 * 800);
    n_valid = 0; n_red = 0; n_leak = 0;
    for (int h = 0; h < 800; h++) begin
      if (rgb_valid_d) n_valid++;
      if (rgb_d == 16'hF800) n_red++;
      if (!rgb_valid_d && rgb_d != 16'h0000) n_leak++;
      case (h)
        142: check("d h142 pix_x", pix_x_d, 10'h3ff);
        143: begin
          check("d h143 pix_x", pix_x_d, 10'd0);
          check("d h143 pix_y", pix_y_d, 10'd0);
          check("d h143 valid", rgb_valid_d, 1'b0);
        end
        144: begin
          check("d h144 valid", rgb_valid_d, 1'b1);
          check("d h144 rgb", rgb_d, 16'hF800);
        end
        782: check("d h782 pix_x", pix_x_d, 10'd639);
        783: begin
          check("d h783 pix_x", pix_x_d, 10'h3ff);
          check("d h783 valid", rgb_valid_d, 1'b1);
        end
        784: begin
          check("d h784 valid", rgb_valid_d, 1'b0);
          check("d h784 rgb", rgb_d, 16'h0000);
        end
        default: ;
      endcase
      goto_d(kd + 1);
    end
    check("d line35 valid count", n_valid, 640);
    check("d line35 F800 count", n_red, 640);
    check("d line35 rgb leak", n_leak, 0);
    goto_d(36 * 800 + 143);
    check("d v36 pix_y", pix_y_d, 10'd1);
    check("d v36 pix_x", pix_x_d, 10'd0);
    // Mid-line reset at v=36, h=400.
    goto_d(36 * 800 + 400);
    check("d pre-rst pix_x", pix_x_d, 10'd257);
    check("d pre-rst valid", rgb_valid_d, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_d("d midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    kd = 0;
    check("d rel k0 hsync", hsync_d, 1'b1);
    goto_d(95); check("d rel k95 hsync", hsync_d, 1'b1);
    goto_d(96); check("d rel k96 hsync", hsync_d, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-002 Parameter H_BACK, 48, horizontal back porch in clocks.
REQ-003 Parameter H_VALID, 640, active pixels per line.
REQ-004 Parameter H_TOTAL, 800, clocks per line.
REQ-005 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-006 Parameter V_BACK, 33, vertical back porch in lines.
REQ-007 Parameter V_VALID, 480, active lines per frame.
REQ-008 Parameter V_TOTAL, 525, lines per frame.
REQ-009 clk  input  1  pixel clock (25 MHz nominal); the block SHALL have one clock.
REQ-010 rst_n  input  1  reset, asynchronous and active-low.
REQ-011 pix_data  input  16  RGB565 pixel from the data stage, registered one clock after pix_x/pix_y.
REQ-012 pix_x  output  10  requested column 0..H_VALID-1; 10'h3ff when no request.
REQ-013 pix_y  output  10  requested row 0..V_VALID-1; 10'h3ff when no request.
REQ-014 hsync  output  1  horizontal sync, high during the sync pulse.
REQ-015 vsync  output  1  vertical sync, high during the sync pulse.
REQ-016 rgb  output  16  RGB565 to the DAC/pins.
REQ-017 rgb_valid  output  1  high while rgb carries an active pixel.

Function
REQ-018 h_cnt (10 bit) SHALL count 0..H_TOTAL-1 on every clk and wrap to 0.
REQ-019 v_cnt (10 bit) SHALL increment when h_cnt==H_TOTAL-1, and SHALL wrap to 0 when v_cnt==V_TOTAL-1 at that same clock.
REQ-020 hsync SHALL be 1 iff h_cnt<H_SYNC; vsync SHALL be 1 iff v_cnt<V_SYNC (combinational decode of registered counters).
REQ-021 rgb_valid SHALL be 1 iff H_SYNC+H_BACK<=h_cnt<H_SYNC+H_BACK+H_VALID and V_SYNC+V_BACK<=v_cnt<V_SYNC+V_BACK+V_VALID.
REQ-022 The request window SHALL be the rgb_valid horizontal window shifted one clock earlier, with the same vertical window, to absorb the data stage's one-clock latency.
REQ-023 Inside the request window: pix_x=h_cnt-(H_SYNC+H_BACK-1), pix_y=v_cnt-(V_SYNC+V_BACK); outside it both SHALL be 10'h3ff.
REQ-024 rgb SHALL equal pix_data when rgb_valid=1, else 16'd0.
REQ-025 Subtractions SHALL be 10-bit unsigned; pix_x never exceeds H_VALID-1 inside the window.
REQ-026 Line end and frame end coinciding (h_cnt=799, v_cnt=524) SHALL wrap both counters to 0 in the same clock.

Reset
REQ-027 rst_n=0 SHALL asynchronously force h_cnt=0 and v_cnt=0, including mid-line or mid-frame.
REQ-028 During reset the outputs SHALL be hsync=1, vsync=1, rgb_valid=0, rgb=0, pix_x=10'h3ff, pix_y=10'h3ff.
REQ-029 After rst_n deassertion, counting SHALL start from h_cnt=0, v_cnt=0 on the first clk edge.

Configuration
REQ-030 Macro VGA_FRAME_CNT_EN defined: add output frame_cnt [15:0], reset 0, incrementing at the wrap in REQ-026 and wrapping 16'hFFFF->0.
REQ-031 Macro VGA_FRAME_CNT_EN undefined: no frame_cnt port or register; all other behaviour identical.

Verification
REQ-032 Release reset -> hsync=1 for clocks 0..95, then 0; next rising edge of hsync at clock 800.
REQ-033 Run a full frame -> vsync=1 for the first 1600 clocks; frame period 420000 clocks.
REQ-034 Line v_cnt=35 -> pix_x=0 at h_cnt=143; rgb_valid rises at h_cnt=144; pix_x=639 at h_cnt=782; pix_x=3ff at h_cnt=783; rgb_valid falls at h_cnt=784; pix_y=0 on this line.
REQ-035 Data stage driving 16'hF800 whenever pix_x/pix_y!=3ff -> rgb=F800 on exactly 640 clocks per line and 480 lines per frame, 0 elsewhere.
REQ-036 Assert rst_n=0 at h_cnt=400, v_cnt=100 -> outputs take the REQ-028 values immediately; after release, hsync=1 for 96 clocks.
REQ-037 With VGA_FRAME_CNT_EN, run 3 frames -> frame_cnt=3; preload 16'hFFFF and complete one frame -> 0.
